// File: rtl/alu_arith_pkg.sv
// rtl/alu_arith_pkg.sv - shared types and helpers for the sequential arithmetic unit
package alu_arith_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        INC  = 3'b010,
        DEC  = 3'b011,
        MUL  = 3'b100,
        DIV  = 3'b101,
        RSV0 = 3'b110,
        RSV1 = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Iteration counter has to hold the value WIDTH itself, not just WIDTH-1
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational adder with carry-in, carry-out and signed overflow
module alu_addsub
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    logic [WIDTH:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    assign sum      = w_full[WIDTH-1:0];
    assign c_out    = w_full[WIDTH];
    // Signed overflow: both addends share a sign and the sum's sign differs from it
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_arith_seq.sv
// rtl/alu_arith_seq.sv - multi-cycle add/sub/inc/dec, shift-add multiply and restoring divide
module alu_arith_seq
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             c_out,
    output logic             negative,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic             r_is_div;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;     // MUL: accumulator, DIV: partial remainder
    logic [WIDTH-1:0] r_lo;     // MUL: multiplier shifting out / product low, DIV: dividend in / quotient out
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_as_a;
    logic [WIDTH-1:0] w_as_b;
    logic             w_as_cin;
    logic [WIDTH-1:0] w_as_sum;
    logic             w_as_c;
    logic             w_as_ovf;

    logic [WIDTH-1:0] w_mul_sum;
    logic             w_mul_c;
    logic             w_unused_mul_ovf;
    logic [WIDTH:0]   w_mul_acc;

    logic [WIDTH-1:0] w_div_sh;
    logic             w_div_take;

    logic [WIDTH-1:0] w_nx_hi;
    logic [WIDTH-1:0] w_nx_lo;

    // Remainder shifted left with the next dividend bit; its top bit drops out of w_div_sh
    assign w_div_sh   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    // Subtract succeeds if the dropped bit was set (value >= 2^WIDTH > b) or no borrow occurred
    assign w_div_take = r_hi[WIDTH-1] | w_as_c;
    // Shift-add step: add multiplicand when the current multiplier bit is 1
    assign w_mul_acc  = r_lo[0] ? {w_mul_c, w_mul_sum} : {1'b0, r_hi};

    // Shared adder operands: trial subtraction while dividing, else the requested single-cycle op
    always_comb begin
        w_as_a   = a;
        w_as_b   = b;
        w_as_cin = 1'b0;
        if (r_state == RUN) begin
            w_as_a   = w_div_sh;
            w_as_b   = ~r_b;
            w_as_cin = 1'b1;
        end else begin
            case (op_t'(op))
                SUB: begin
                    w_as_b   = ~b;
                    w_as_cin = 1'b1;
                end
                INC: begin
                    w_as_b   = '0;
                    w_as_cin = 1'b1;
                end
                DEC: begin
                    w_as_b   = '1;
                end
                default: ;
            endcase
        end
    end

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (w_as_a),
        .b        (w_as_b),
        .c_in     (w_as_cin),
        .sum      (w_as_sum),
        .c_out    (w_as_c),
        .overflow (w_as_ovf)
    );

    alu_addsub #(.WIDTH(WIDTH)) u_mul_add (
        .a        (r_hi),
        .b        (r_b),
        .c_in     (1'b0),
        .sum      (w_mul_sum),
        .c_out    (w_mul_c),
        .overflow (w_unused_mul_ovf)
    );

    // Next iteration state for whichever long operation is running
    always_comb begin
        w_nx_hi = w_mul_acc[WIDTH:1];
        w_nx_lo = {w_mul_acc[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            w_nx_hi = w_div_take ? w_as_sum : w_div_sh;
            w_nx_lo = {r_lo[WIDTH-2:0], w_div_take};
        end
    end

    // Control FSM with registered result, flags and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_div    <= 1'b0;
            r_b         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            c_out       <= 1'b0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        case (op_t'(op))
                            ADD, SUB, INC, DEC: begin
                                result      <= w_as_sum;
                                result_hi   <= '0;
                                c_out       <= w_as_c;
                                negative    <= w_as_sum[WIDTH-1];
                                overflow    <= w_as_ovf;
                                zero        <= (w_as_sum == '0);
                                div_by_zero <= 1'b0;
                                done        <= 1'b1;
                            end
                            MUL, DIV: begin
                                r_is_div <= (op_t'(op) == DIV);
                                r_b      <= b;
                                r_hi     <= '0;
                                r_lo     <= a;
                                r_cnt    <= CW'(WIDTH);
                                r_state  <= RUN;
                                busy     <= 1'b1;
                            end
                            default: begin
                                result      <= '0;
                                result_hi   <= '0;
                                c_out       <= 1'b0;
                                negative    <= 1'b0;
                                overflow    <= 1'b0;
                                zero        <= 1'b1;
                                div_by_zero <= 1'b0;
                                done        <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    r_hi  <= w_nx_hi;
                    r_lo  <= w_nx_lo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        result    <= w_nx_lo;
                        result_hi <= w_nx_hi;
                        negative  <= w_nx_lo[WIDTH-1];
                        zero      <= (w_nx_lo == '0);
                        if (r_is_div) begin
                            c_out       <= 1'b0;
                            overflow    <= 1'b0;
                            div_by_zero <= (r_b == '0);
                        end else begin
                            c_out       <= |w_nx_hi;
                            overflow    <= |w_nx_hi;
                            div_by_zero <= 1'b0;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arith_seq.sv
// tb/tb_alu_arith_seq.sv - self-checking bench for alu_arith_seq
module tb_alu_arith_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         n;
        logic         v;
        logic         z;
        logic         dbz;
    } res_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         c_out;
    logic         negative;
    logic         overflow;
    logic         zero;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl [14];

    always #5 clk = ~clk;

    alu_arith_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .c_out       (c_out),
        .negative    (negative),
        .overflow    (overflow),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t sample();
        res_t r;
        r.res = result;
        r.hi  = result_hi;
        r.c   = c_out;
        r.n   = negative;
        r.v   = overflow;
        r.z   = zero;
        r.dbz = div_by_zero;
        return r;
    endfunction

    task automatic check_res(input string tag, input res_t got, input res_t exp);
        check({tag, " result"},      32'(got.res), 32'(exp.res));
        check({tag, " result_hi"},   32'(got.hi),  32'(exp.hi));
        check({tag, " c_out"},       32'(got.c),   32'(exp.c));
        check({tag, " negative"},    32'(got.n),   32'(exp.n));
        check({tag, " overflow"},    32'(got.v),   32'(exp.v));
        check({tag, " zero"},        32'(got.z),   32'(exp.z));
        check({tag, " div_by_zero"}, 32'(got.dbz), 32'(exp.dbz));
    endtask

    // Arithmetic reference: plain integer maths on the operand values
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        int ux, uy, sx, sy, full, sfull;
        int lim, smax, smin;
        lim  = 1 << W;
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        r = '0;
        full = 0;
        sfull = 0;
        case (o)
            3'd0: begin full = ux + uy; sfull = sx + sy; r.c = (full >= lim); end
            3'd1: begin full = ux - uy; sfull = sx - sy; r.c = (ux >= uy); end
            3'd2: begin full = ux + 1;  sfull = sx + 1;  r.c = (full >= lim); end
            3'd3: begin full = ux - 1;  sfull = sx - 1;  r.c = (ux != 0); end
            3'd4: begin
                full = ux * uy;
                r.hi = W'(full >> W);
                r.c  = (r.hi != '0);
                r.v  = r.c;
            end
            3'd5: begin
                if (uy == 0) begin
                    full  = lim - 1;
                    r.hi  = x;
                    r.dbz = 1'b1;
                end else begin
                    full = ux / uy;
                    r.hi = W'(ux % uy);
                end
            end
            default: full = 0;
        endcase
        r.res = W'(full);
        if (o <= 3'd3) r.v = (sfull > smax) || (sfull < smin);
        r.n = r.res[W-1];
        r.z = (r.res == '0);
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic c, input logic n, input logic v, input logic z, input logic d);
        vec_t t;
        t.op = o; t.a = x; t.b = y;
        t.e.res = r; t.e.hi = h; t.e.c = c; t.e.n = n; t.e.v = v; t.e.z = z; t.e.dbz = d;
        return t;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound)
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int nbusy);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        lat   = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) nbusy++;
        end while (!done && lat < 40);
    endtask

    task automatic run_check(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input res_t exp);
        int lat, nb;
        bit is_long;
        is_long = (o == 3'd4) || (o == 3'd5);
        issue(o, x, y, lat, nb);
        check({tag, " latency"}, 32'(lat), is_long ? 32'(W + 1) : 32'd1);
        check({tag, " busy_cycles"}, 32'(nb), is_long ? 32'(W) : 32'd0);
        check_res(tag, sample(), exp);
    endtask

    initial begin
        int lat, nb;
        logic [2:0]   ro;
        logic [W-1:0] rx, ry;
        res_t         exp_r;

        tbl[0]  = mk(3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mk(3'd1, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(3'd1, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(3'd2, 8'hFF, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mk(3'd3, 8'h80, 8'h33, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(3'd4, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(3'd5, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(3'd5, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(3'd6, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(3'd7, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[11] = mk(3'd4, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[12] = mk(3'd5, 8'd7, 8'd200, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[13] = mk(3'd0, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check_res("reset", sample(), '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle done", 32'(done), 32'd0);

        // Directed vectors
        foreach (tbl[i]) begin
            run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
        end

        // MUL with a stray start in N+3 that must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 8'hFF; b = 8'hFF;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= W) begin
                check($sformatf("mulign busy@%0d", k), 32'(busy), 32'd1);
                check($sformatf("mulign done@%0d", k), 32'(done), 32'd0);
            end else begin
                check("mulign busy@end", 32'(busy), 32'd0);
                check("mulign done@end", 32'(done), 32'd1);
                check_res("mulign", sample(), model(3'd4, 8'hFF, 8'hFF));
            end
            if (k == 3) begin
                start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
            end
        end
        @(negedge clk);
        check("mulign single done", 32'(done), 32'd0);
        check("mulign hold result", 32'(result), 32'h01);

        // Reset in the middle of a MUL: no done, everything back to zero
        start = 1'b1; op = 3'd4; a = 8'hFF; b = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("mulrst done@%0d", k), 32'(done), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mulrst done", 32'(done), 32'd0);
        check("mulrst busy", 32'(busy), 32'd0);
        check_res("mulrst", sample(), '0);
        run_check("post_rst_add", 3'd0, 8'h02, 8'h03, model(3'd0, 8'h02, 8'h03));
        check("post_rst_add value", 32'(result), 32'h05);

        // Randomized back-to-back and gapped traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = W'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            exp_r = model(ro, rx, ry);
            run_check($sformatf("rnd%0d op%0d %0h,%0h", i, ro, rx, ry), ro, rx, ry, exp_r);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check($sformatf("rnd%0d hold done", i), 32'(done), 32'd0);
                check($sformatf("rnd%0d hold result", i), 32'(result), 32'(exp_r.res));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/alu_arith_seq.md
# alu_arith_seq

Parametrised, multi-cycle arithmetic unit for the CPU datapath that replaces the purely combinational add/subtract unit. It performs single-cycle add, subtract, increment and decrement. It also performs iterative unsigned multiply (shift-add) and unsigned divide (restoring). Results and flags are registered, and a start/busy/done handshake lets the control unit stall on long operations.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 4)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy = 0
- op  in  3  operation, latched with start: 000 ADD, 001 SUB, 010 INC, 011 DEC, 100 MUL, 101 DIV, 110/111 reserved
- a  in  WIDTH  operand A, latched with start
- b  in  WIDTH  operand B, latched with start
- busy  out  1  high while MUL/DIV iterates
- done  out  1  one-cycle pulse when result/flags update
- result  out  WIDTH  sum/difference, low product, or quotient
- result_hi  out  WIDTH  high product or remainder; 0 for other ops
- c_out  out  1  carry (ADD/INC/DEC), no-borrow (SUB), result_hi ≠ 0 (MUL), 0 (DIV)
- negative  out  1  result[WIDTH-1]
- overflow  out  1  signed overflow (ADD/SUB/INC/DEC); equals c_out for MUL; 0 for DIV
- zero  out  1  result == 0
- div_by_zero  out  1  DIV with b == 0; 0 otherwise

## Operation
- Reset: state IDLE; all outputs and internal registers 0.
- States: IDLE, RUN.
  - IDLE + start + single-cycle op: compute and register outputs, pulse done, stay IDLE.
  - IDLE + start + MUL/DIV: latch operands, clear the accumulator, load the iteration counter with WIDTH, go to RUN.
  - RUN: one iteration per cycle; the counter decrements. When the counter reaches 0, register outputs, pulse done, return to IDLE.
- Adder convention:
  - ADD: a + b + 0
  - SUB: a + ~b + 1
  - INC: a + 0 + 1
  - DEC: a + all-ones + 0
  - Overflow = operands' MSBs equal and result MSB differs from them.
- MUL: unsigned; {result_hi, result} = a × b, full 2·WIDTH-bit product.
- DIV: unsigned; result = quotient, result_hi = remainder.
  - b == 0: still takes WIDTH cycles; result = all-ones, result_hi = a, div_by_zero = 1.
- Reserved op: completes as a single-cycle op; result = 0, result_hi = 0, flags 0 except zero = 1.
- start while busy = 1: ignored; the in-flight op is unaffected.
- Outputs hold their last value between done pulses.
- rst mid-RUN: aborts with no done pulse; everything returns to reset values.

## Timing
- start sampled high in cycle N.
- Single-cycle op:
  - Outputs valid and done = 1 in cycle N+1.
  - busy stays 0.
  - A new start is accepted in cycle N+1.
- MUL/DIV:
  - busy = 1 in cycles N+1 … N+WIDTH.
  - Outputs valid and done = 1, busy = 0 in cycle N+WIDTH+1.
  - A new start is accepted in that same cycle (back-to-back).
- done is never high for two consecutive cycles for the same request.
- No combinational path from inputs to outputs.

## Structure
- Package alu_arith_pkg: op_t enum (ADD, SUB, INC, DEC, MUL, DIV, RSV0, RSV1), state_t enum (IDLE, RUN), and a helper constant for the iteration-counter width, $clog2(WIDTH+1).
- Sub-module alu_addsub: combinational WIDTH-bit adder with inputs a, b, c_in and outputs sum, c_out, overflow.
  - Instantiated once for ADD/SUB/INC/DEC.
  - Reused for the trial subtraction in DIV; the MUL add uses a second instance.

## Test plan
- ADD, WIDTH=8, a=8'h7F, b=8'h01 -> result 8'h80, negative 1, overflow 1, c_out 0, done in N+1, busy never high.
- SUB, a=8'h05, b=8'h07 -> result 8'hFE, c_out 0, negative 1. SUB, a=b=8'h05 -> result 0, zero 1, c_out 1.
- INC, a=8'hFF -> result 8'h00, c_out 1, zero 1, overflow 0. DEC, a=8'h80 -> result 8'h7F, overflow 1.
- MUL, a=b=8'hFF -> result 8'h01, result_hi 8'hFE, c_out 1, overflow 1. busy high exactly 8 cycles, done in N+9. A start pulsed at N+3 is ignored.
- DIV, a=8'd200, b=8'd7 -> result 8'h1C, result_hi 8'h04. DIV, a=8'h05, b=0 -> result 8'hFF, result_hi 8'h05, div_by_zero 1, done in N+9.
- MUL started, rst asserted in N+4 -> no done, all outputs 0 in N+5. A following ADD 8'h02+8'h03 -> 8'h05 in one cycle.
